dcr: RTL and testbench
======================

DCR -- requirements
Module: dcr

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the control data input and of the thread_count register.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into thread_count on reset; SHALL fit in DATA_WIDTH bits.
REQ-003 clk  input  1  single clock; all state SHALL update only on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 device_control_write_enable  input  1  write strobe; high for one or more cycles to load device_control_data.
REQ-006 device_control_data  input  DATA_WIDTH  value to store into the device control register.
REQ-007 thread_count  output  DATA_WIDTH  current register contents; number of threads the GPU is to launch.
REQ-008 The module SHALL have one clock and one reset; reset is synchronous and active-high, sampled only on rising clk.

Function
REQ-009 The block SHALL hold one DATA_WIDTH-bit register, the device control register (DCR).
REQ-010 thread_count SHALL be driven directly from the DCR register bits, with no combinational path from any input.
REQ-011 On a rising edge with reset=1, DCR SHALL load RESET_VALUE (0x00 at defaults), regardless of write enable or data.
REQ-012 On a rising edge with reset=0 and device_control_write_enable=1, DCR SHALL load device_control_data unmodified (all bits, no masking or saturation).
REQ-013 On a rising edge with reset=0 and device_control_write_enable=0, DCR SHALL hold its value.
REQ-014 Write latency SHALL be one cycle: the new value appears on thread_count after the capturing edge and persists until the next write or reset.
REQ-015 Reset SHALL take priority over a simultaneous write; the write in that cycle SHALL be discarded, not deferred.
REQ-016 Back-to-back writes on consecutive cycles SHALL each take effect; the last written value wins.
REQ-017 Changes on device_control_data while write enable is low SHALL have no effect on thread_count.
REQ-018 Any value 0x00..0xFF (at DATA_WIDTH=8) SHALL be accepted; no range checking or wrap-around.
REQ-019 The block SHALL have no handshake, busy or ready signalling; every asserted write cycle is accepted.

Reset
REQ-020 Reset SHALL be synchronous; asserting it between edges SHALL not change thread_count until the next rising clk.
REQ-021 After one rising edge with reset=1, thread_count SHALL equal RESET_VALUE (0x00 at defaults).
REQ-022 Reset asserted mid-operation SHALL discard the previously written value; after deassertion, thread_count SHALL stay RESET_VALUE until a write.
REQ-023 Before the first reset edge, thread_count SHALL be undefined; the design SHALL not rely on an initial value.

Verification
REQ-024 Reset high for one edge, write enable 0 -> thread_count = 0x00.
REQ-025 After reset, write enable=1 with data=0xAB for one edge, then enable 0 -> thread_count = 0xAB after that edge and still 0xAB two cycles later.
REQ-026 thread_count=0xAB, reset high for one edge, then low -> thread_count = 0x00 and stays 0x00 with write enable low.
REQ-027 Write enable low while data toggles 0x55/0xFF over several edges -> thread_count unchanged from its prior value.
REQ-028 Reset=1 and write enable=1 with data=0x3C on the same edge -> thread_count = 0x00.
REQ-029 Consecutive write cycles with data 0x01, 0xFF, 0x00 -> thread_count follows 0x01, 0xFF, 0x00 one edge after each write.

Source files
------------

// File: rtl/dcr.sv
// Device control register: a single DATA_WIDTH-bit register whose contents tell
// the GPU how many threads to launch. It loads on a write strobe and holds otherwise.
module dcr #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  device_control_write_enable,
    input  logic [DATA_WIDTH-1:0] device_control_data,
    output logic [DATA_WIDTH-1:0] thread_count
);

    logic [DATA_WIDTH-1:0] dcr_reg;
    logic [DATA_WIDTH-1:0] dcr_next;

    always_comb begin
        dcr_next = dcr_reg;
        if (device_control_write_enable) begin
            dcr_next = device_control_data;
        end
    end

    // Reset wins over a same-cycle write; that write is dropped, not deferred.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_dcr_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    dcr_reg[gi] <= RESET_VALUE[gi];
                end else begin
                    dcr_reg[gi] <= dcr_next[gi];
                end
            end
        end
    endgenerate

    assign thread_count = dcr_reg;

endmodule

// File: tb/tb_dcr.sv
// Scoreboard bench for dcr: each driven cycle pushes the expected thread_count,
// which is popped and compared one edge later.
module tb_dcr;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          device_control_write_enable;
    logic [DW-1:0] device_control_data;
    logic [DW-1:0] thread_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_reg;

    dcr #(.DATA_WIDTH(DW), .RESET_VALUE(8'h00)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .device_control_write_enable (device_control_write_enable),
        .device_control_data         (device_control_data),
        .thread_count                (thread_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Drive one cycle (called just after a rising edge), then compare after the next edge.
    task automatic cycle(input string tag, input logic r, input logic we, input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        reset = r;
        device_control_write_enable = we;
        device_control_data = d;
        if (r)       model_reg = 8'h00;
        else if (we) model_reg = d;
        exp_q.push_back(model_reg);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got=%h", tag, thread_count);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, thread_count, exp);
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] rd;
        reset = 1'b0;
        device_control_write_enable = 1'b0;
        device_control_data = '0;
        model_reg = 'x;
        @(posedge clk);
        #1;

        cycle("reset", 1'b1, 1'b0, 8'h5A);
        cycle("idle_after_reset", 1'b0, 1'b0, 8'h77);

        cycle("write_ab", 1'b0, 1'b1, 8'hAB);
        cycle("hold_ab_1", 1'b0, 1'b0, 8'h00);
        cycle("hold_ab_2", 1'b0, 1'b0, 8'h00);

        // Reset raised between edges must not act until the next edge.
        reset = 1'b1;
        #2;
        check_eq("sync_reset_before_edge", thread_count, 8'hAB);
        cycle("reset_mid_op", 1'b1, 1'b0, 8'h00);
        cycle("post_reset_hold_1", 1'b0, 1'b0, 8'hCD);
        cycle("post_reset_hold_2", 1'b0, 1'b0, 8'hEF);

        cycle("write_66", 1'b0, 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) begin
            cycle("data_toggle_no_we", 1'b0, 1'b0, (i % 2 == 0) ? 8'h55 : 8'hFF);
        end

        cycle("reset_beats_write", 1'b1, 1'b1, 8'h3C);
        cycle("write_discarded", 1'b0, 1'b0, 8'h3C);

        cycle("b2b_01", 1'b0, 1'b1, 8'h01);
        cycle("b2b_ff", 1'b0, 1'b1, 8'hFF);
        cycle("b2b_00", 1'b0, 1'b1, 8'h00);
        cycle("b2b_hold", 1'b0, 1'b0, 8'hA5);

        for (int i = 0; i < 8; i++) begin
            cycle("walk_one", 1'b0, 1'b1, 8'(1 << i));
        end

        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom_range(0, 255));
            cycle("random", ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), rd);
        end

        held = model_reg;
        cycle("final_hold", 1'b0, 1'b0, ~held);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
